instr_fetch_queue: RTL

//  Fetch stage directly downstream of the program counter. Takes each PC value,

---
 rtl/ifq_pkg.sv | 24 ++
 rtl/instr_fetch_queue_if.sv | 34 +++
 rtl/ifq_slot_array.sv | 41 ++++
 rtl/instr_fetch_queue.sv | 115 +++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// Shared types, width defaults and helpers for the instruction fetch queue.
// Imported by the interface, the slot array and the top.
package ifq_pkg;

  localparam int unsigned IFQ_ADDR_W = 32;
  localparam int unsigned IFQ_DATA_W = 32;

  typedef struct packed {
    logic [IFQ_ADDR_W-1:0] pc;
    logic [IFQ_DATA_W-1:0] data;
    logic                  filled;
  } ifq_entry_t;

  // Ceiling log2, usable in constant expressions for pointer widths.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if (value > (32'd1 << i)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Handshake bundle between PC, instruction memory, decode and the fetch queue.
// slave = fetch queue side, master = surrounding environment.
interface instr_fetch_queue_if
  import ifq_pkg::*;
#(
  parameter int unsigned ADDR_W = IFQ_ADDR_W,
  parameter int unsigned DATA_W = IFQ_DATA_W
);

  logic [ADDR_W-1:0] pc_in;
  logic              pc_valid;
  logic              pc_ready;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              flush;
  logic              ir_valid;
  logic [DATA_W-1:0] ir_data;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_ready;

  modport slave (
    input  pc_in, pc_valid, mem_gnt, mem_rvalid, mem_rdata, flush, ir_ready,
    output pc_ready, mem_req, mem_addr, ir_valid, ir_data, ir_pc
  );

  modport master (
    output pc_in, pc_valid, mem_gnt, mem_rvalid, mem_rdata, flush, ir_ready,
    input  pc_ready, mem_req, mem_addr, ir_valid, ir_data, ir_pc
  );

endinterface

// File: rtl/ifq_slot_array.sv
// DEPTH-entry storage for the fetch queue: allocate (pc), fill (data) and read ports.
// Allocation clears the filled flag; a fill sets it.
module ifq_slot_array
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alloc_en,
  input  logic [IDX_W-1:0]      alloc_idx,
  input  logic [IFQ_ADDR_W-1:0] alloc_pc,
  input  logic                  fill_en,
  input  logic [IDX_W-1:0]      fill_idx,
  input  logic [IFQ_DATA_W-1:0] fill_data,
  input  logic [IDX_W-1:0]      rd_idx,
  output ifq_entry_t            rd_entry
);

  ifq_entry_t slot_q [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
    end else begin
      // Alloc and fill never target the same slot: that would need DEPTH unfilled entries.
      if (alloc_en) begin
        slot_q[alloc_idx].pc     <= alloc_pc;
        slot_q[alloc_idx].filled <= 1'b0;
      end
      if (fill_en) begin
        slot_q[fill_idx].data   <= fill_data;
        slot_q[fill_idx].filled <= 1'b1;
      end
    end
  end

  assign rd_entry = slot_q[rd_idx];

endmodule

// File: rtl/instr_fetch_queue.sv
// In-order instruction fetch queue between the PC and decode, with flush and drop tracking.
// Define IFQ_BYPASS_EN to forward a response for an unfilled head slot to decode in-cycle.
module instr_fetch_queue
  import ifq_pkg::*;
#(
  parameter int unsigned ADDR_W = IFQ_ADDR_W,
  parameter int unsigned DATA_W = IFQ_DATA_W,
  parameter int unsigned DEPTH  = 4
) (
  input logic                clock,
  input logic                reset,
  instr_fetch_queue_if.slave bus
);

  localparam int unsigned IDX_W  = clog2(DEPTH);
  localparam int unsigned PTR_W  = IDX_W + 1;
  // One extra bit: back-to-back flushes can stack drops beyond DEPTH.
  localparam int unsigned DROP_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  fill_ptr_q, fill_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [PTR_W-1:0]  unfilled;
  logic              full, empty;
  logic              issue, resp_live, fill_write, pop;
  logic              head_filled;
  ifq_entry_t        head;

  assign unfilled = wr_ptr_q - fill_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                    (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

  // Issue uses registered occupancy only: a same-cycle pop never frees the slot early.
  assign bus.mem_req  = reset & bus.pc_valid & ~full & ~bus.flush;
  assign bus.mem_addr = bus.pc_in;
  assign issue        = bus.mem_req & bus.mem_gnt;
  assign bus.pc_ready = issue;

  assign resp_live   = bus.mem_rvalid & (drop_cnt_q == '0) & ~bus.flush;
  assign head_filled = ~empty & head.filled;

`ifdef IFQ_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit   = resp_live & ~empty & (fill_ptr_q == rd_ptr_q);
  assign bus.ir_valid = head_filled | bypass_hit;
  assign bus.ir_data  = bypass_hit ? bus.mem_rdata : head.data;
  assign pop          = bus.ir_valid & bus.ir_ready & ~bus.flush;
  // A forwarded entry that pops immediately is never marked filled.
  assign fill_write   = resp_live & ~(bypass_hit & pop);
`else
  assign bus.ir_valid = head_filled;
  assign bus.ir_data  = head.data;
  assign pop          = bus.ir_valid & bus.ir_ready & ~bus.flush;
  assign fill_write   = resp_live;
`endif
  assign bus.ir_pc = head.pc;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    fill_ptr_d = fill_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    drop_cnt_d = drop_cnt_q;
    if (bus.flush) begin
      fill_ptr_d = wr_ptr_q;
      rd_ptr_d   = wr_ptr_q;
      // A response this cycle retires either a pending drop or an unfilled slot.
      drop_cnt_d = drop_cnt_q + DROP_W'(unfilled) - DROP_W'(bus.mem_rvalid);
    end else begin
      if (issue) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (resp_live) begin
        fill_ptr_d = fill_ptr_q + PTR_W'(1);
      end else if (bus.mem_rvalid) begin
        drop_cnt_d = drop_cnt_q - DROP_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      fill_ptr_q <= '0;
      rd_ptr_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      fill_ptr_q <= fill_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  ifq_slot_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_slots (
    .clock     (clock),
    .reset     (reset),
    .alloc_en  (issue),
    .alloc_idx (wr_ptr_q[IDX_W-1:0]),
    .alloc_pc  (bus.pc_in),
    .fill_en   (fill_write),
    .fill_idx  (fill_ptr_q[IDX_W-1:0]),
    .fill_data (bus.mem_rdata),
    .rd_idx    (rd_ptr_q[IDX_W-1:0]),
    .rd_entry  (head)
  );

  resp_has_slot_a: assert property (@(posedge clock) disable iff (!reset)
    (bus.mem_rvalid && (drop_cnt_q == '0)) |-> (unfilled != '0));

endmodule
